osnt_bram_replay_ctrl: RTL
==========================

# osnt_bram_replay_ctrl

Sequencing and sharing controller for the OSNT single-port packet BRAM. It arbitrates between a host register-side access port (load/readback of stored words) and a replay engine that streams a configured address window out as a valid/ready stream, optionally looping. It sits between the BRAM instance and the generator output path, owns every BRAM control signal, and never resets memory contents.

## Interface
- ADDR_WIDTH, 16, BRAM word address width
- DATA_WIDTH, 736, BRAM word width (packed stream beat)
- FIFO_DEPTH, 4, output buffer entries (fixed at 4, power of two)
- bram_clk  in  1  sole clock; everything is synchronous to its rising edge
- bram_rst  in  1  reset, asynchronous, active-high
- host_req  in  1  host access request; held until host_ack
- host_we  in  1  1 = write, 0 = read; stable while host_req
- host_addr  in  ADDR_WIDTH  host word address
- host_wrdata  in  DATA_WIDTH  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rddata  out  DATA_WIDTH  read data, valid when host_ack and !host_we
- start  in  1  one-cycle replay start pulse
- stop  in  1  one-cycle replay stop pulse
- start_addr, end_addr  in  ADDR_WIDTH each  inclusive replay window
- loop_count  in  16  number of window passes; 0 = infinite until stop
- busy  out  1  high in any state other than IDLE
- cfg_err  out  1  sticky: start rejected because end_addr < start_addr
- loops_done  out  32  completed passes of current/last replay
- m_data  out  DATA_WIDTH  replayed word
- m_valid  out  1  / m_ready  in  1  output handshake
- m_last  out  1  word came from end_addr
- bram_addr  out  ADDR_WIDTH / bram_wrdata  out  DATA_WIDTH / bram_en  out  1 / bram_we  out  1 — registered BRAM controls
- bram_rddata  in  DATA_WIDTH  BRAM read data, one cycle after bram_en

## Operation
- States: IDLE, HOST, RUN, DRAIN. BRAM reset input is tied low by the integrator; the controller has no bram_rst output.
- IDLE: start has priority over host_req in the same cycle. Valid start (end_addr >= start_addr) latches window and loop_count, clears loops_done and cfg_err, goes to RUN. Invalid start sets cfg_err, stays IDLE. Otherwise host_req -> HOST.
- HOST: drives bram_en=1, bram_we=host_we, bram_addr/bram_wrdata for exactly one cycle; next cycle pulses host_ack (host_rddata = bram_rddata on reads; writes return read-before-write data, don't-care), returns to IDLE. host_req during RUN/DRAIN is stalled, not dropped.
- RUN: issues a read when count + inflight < FIFO_DEPTH (inflight = reads decided but not yet written into FIFO, max 2). Address increments; after end_addr it wraps to start_addr and loops_done increments when the end_addr word is pushed. When loops_done reaches a nonzero loop_count, no more reads issue -> DRAIN.
- stop in RUN: no further issues -> DRAIN. stop in IDLE/HOST/DRAIN: ignored. start while busy: ignored.
- DRAIN: completes inflight reads, empties FIFO through m_*, then IDLE.
- FIFO: 4 entries storing {last, data}; m_valid = !empty; pop on m_valid && m_ready; simultaneous push and pop allowed at any occupancy (never overflows by credit rule).
- loops_done saturates at 2^32-1.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0.
- Host access: req sampled at cycle N, bram_en at N+1, host_ack at N+2; next req accepted at N+3.
- Replay: start at N, first bram_en at N+1, first m_valid at N+3; with m_ready held high one word per cycle sustained, including across wrap.
- Backpressure: m_ready low halts issue within 2 cycles; no word lost or duplicated.
- Reset mid-operation: immediate return to IDLE, FIFO flushed, host_ack not issued; memory contents preserved.

## Test plan
- Host write 0xA5.. to addr 5, read addr 5 -> host_ack at req+2 each, host_rddata equals written word.
- Load addrs 0..3, start window 0..3, loop_count=2, m_ready=1 -> 8 consecutive beats 0,1,2,3,0,1,2,3, m_last on 4th and 8th, loops_done=2, busy falls after last beat.
- Same with m_ready toggling 1/0 randomly -> identical sequence, no drops/duplicates, FIFO never exceeds 4.
- loop_count=0, window 10..12, stop after 7 beats -> stream ends on a clean drain (no beat after inflight words), busy=0, host access then succeeds.
- start with start_addr=8, end_addr=3 -> cfg_err=1, busy stays 0; later valid start clears cfg_err.
- host_req asserted during RUN -> no host_ack until replay completes, then ack 2 cycles after IDLE; async reset asserted mid-RUN -> all outputs 0 immediately, preloaded words still readable after.

Source files
------------

// File: rtl/osnt_bram_replay_ctrl.sv
// osnt_bram_replay_ctrl: shares a single-port packet BRAM between host access and a looping replay stream
module osnt_bram_replay_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 736,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  bram_clk,
  input  logic                  bram_rst,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wrdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rddata,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [15:0]           loop_count,
  output logic                  busy,
  output logic                  cfg_err,
  output logic [31:0]           loops_done,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wrdata,
  output logic                  bram_en,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_rddata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, HOST, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_start, r_end, r_addr, r_bram_addr;
  logic [15:0] r_loops, r_pass;
  logic [31:0] r_loops_done;
  logic r_cfg_err, r_host_ack, r_bram_en, r_bram_we, r_iss, r_iss_last, r_rd_v, r_rd_last;
  logic [DATA_WIDTH-1:0] r_bram_wrdata;
  logic [PW:0] r_cnt;
  logic [PW-1:0] r_wp, r_rp;
  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic w_idle, w_start_ok, w_pop, w_credit, w_last_addr, w_final, w_issue, w_host_go, w_drained;
  logic [ADDR_WIDTH-1:0] w_iss_addr, w_wrap_addr;
  logic [15:0] w_pass, w_lc;
  // In IDLE the first read is issued straight from the start inputs so bram_en follows start by one cycle
  assign w_idle      = r_state == IDLE;
  assign w_start_ok  = start && end_addr >= start_addr;
  assign w_pop       = r_cnt != '0 && m_ready;
  assign w_credit    = r_cnt + (PW+1)'(r_iss) + (PW+1)'(r_rd_v) < (PW+1)'(FIFO_DEPTH);
  assign w_iss_addr  = w_idle ? start_addr : r_addr;
  assign w_wrap_addr = w_idle ? start_addr : r_start;
  assign w_last_addr = w_iss_addr == (w_idle ? end_addr : r_end);
  assign w_pass      = w_idle ? '0 : r_pass;
  assign w_lc        = w_idle ? loop_count : r_loops;
  assign w_final     = w_lc != '0 && w_last_addr && w_pass + 16'd1 == w_lc;
  assign w_drained   = !r_iss && !r_rd_v && (r_cnt == '0 || (r_cnt == (PW+1)'(1) && w_pop));
  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_host_go = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_issue = w_start_ok;
          w_next  = !w_start_ok ? IDLE : w_final ? DRAIN : RUN;
        end else if (host_req && !r_host_ack) begin
          w_host_go = 1'b1;
          w_next    = HOST;
        end
      end
      HOST: w_next = IDLE;
      RUN: begin
        if (stop) w_next = DRAIN;
        else if (w_credit) begin
          w_issue = 1'b1;
          w_next  = w_final ? DRAIN : RUN;
        end
      end
      default: w_next = w_drained ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      r_state       <= IDLE;
      r_bram_en     <= 1'b0;
      r_bram_we     <= 1'b0;
      r_bram_addr   <= '0;
      r_bram_wrdata <= '0;
      r_host_ack    <= 1'b0;
      r_iss         <= 1'b0;
      r_iss_last    <= 1'b0;
      r_rd_v        <= 1'b0;
      r_rd_last     <= 1'b0;
      r_addr        <= '0;
      r_pass        <= '0;
      r_start       <= '0;
      r_end         <= '0;
      r_loops       <= '0;
      r_loops_done  <= '0;
      r_cfg_err     <= 1'b0;
      r_wp          <= '0;
      r_rp          <= '0;
      r_cnt         <= '0;
    end else begin
      r_state    <= w_next;
      r_bram_en  <= w_issue || w_host_go;
      r_bram_we  <= w_host_go && host_we;
      r_host_ack <= r_state == HOST;
      r_iss      <= w_issue;
      r_iss_last <= w_issue && w_last_addr;
      r_rd_v     <= r_iss;
      r_rd_last  <= r_iss_last;
      if (w_host_go || w_issue) r_bram_addr <= w_host_go ? host_addr : w_iss_addr;
      if (w_host_go) r_bram_wrdata <= host_wrdata;
      if (w_issue) begin
        r_addr <= w_last_addr ? w_wrap_addr : w_iss_addr + 1'b1;
        r_pass <= w_pass + 16'(w_last_addr);
      end
      if (w_idle && start) begin
        r_cfg_err <= !w_start_ok;
        if (w_start_ok) begin
          r_start      <= start_addr;
          r_end        <= end_addr;
          r_loops      <= loop_count;
          r_loops_done <= '0;
        end
      end else if (r_rd_v && r_rd_last && r_loops_done != '1) r_loops_done <= r_loops_done + 32'd1;
      if (r_rd_v) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(r_rd_v) - (PW+1)'(w_pop);
    end
  end
  always_ff @(posedge bram_clk) begin
    if (r_rd_v) r_mem[r_wp] <= {r_rd_last, bram_rddata};
  end
  assign busy        = !w_idle;
  assign cfg_err     = r_cfg_err;
  assign loops_done  = r_loops_done;
  assign host_ack    = r_host_ack;
  assign host_rddata = r_host_ack ? bram_rddata : '0;
  assign m_valid     = r_cnt != '0;
  assign m_data      = m_valid ? r_mem[r_rp][DATA_WIDTH-1:0] : '0;
  assign m_last      = m_valid && r_mem[r_rp][DATA_WIDTH];
  assign bram_addr   = r_bram_addr;
  assign bram_wrdata = r_bram_wrdata;
  assign bram_en     = r_bram_en;
  assign bram_we     = r_bram_we;
endmodule
